// File: rtl/booth_mult_seq_if.sv
// booth_mult_seq_if: operand/result bundle for the sequential Booth multiplier.
// Latency: n/a (wiring only). Backpressure: none; start is a strobe, done a one-cycle pulse.
// Signals: start, multiplicand[N], multiplier[N] (requester -> multiplier),
//          product[2N], busy, done (multiplier -> requester).
interface booth_mult_seq_if #(
    parameter int N = 8
);
    logic                  start;
    logic signed [N-1:0]   multiplicand;
    logic signed [N-1:0]   multiplier;
    logic signed [2*N-1:0] product;
    logic                  busy;
    logic                  done;

    // Requester side: drives the operands and the start strobe.
    modport master (
        output start,
        output multiplicand,
        output multiplier,
        input  product,
        input  busy,
        input  done
    );

    // Multiplier side.
    modport slave (
        input  start,
        input  multiplicand,
        input  multiplier,
        output product,
        output busy,
        output done
    );
endinterface

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier, one add/sub-and-shift step per clock.
// Latency: start edge + N step edges; done pulses the cycle after the last step (N+1 clocks).
// Backpressure: none; start is ignored while busy, accepted in IDLE or in the DONE cycle.
// Ports: clk (rising edge), rst (async, active-high), bus (booth_mult_seq_if.slave:
//        start, multiplicand, multiplier in; product, busy, done out).
// Option: define BOOTH_ZERO_SKIP_EN to finish immediately (product 0, done next cycle,
//         busy never set) when either operand is zero.
module booth_mult_seq #(
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              rst,
    booth_mult_seq_if.slave   bus
);
    localparam int CW = $clog2(N + 1);
    localparam logic [N:0] ONE = (N + 1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [N:0]        a_q;      // accumulator, one guard bit so M = -2^(N-1) negates cleanly
    logic [N:0]        m_q;      // sign-extended multiplicand
    logic [N:0]        q_q;      // {multiplier bits still to consume, q_-1}
    logic [CW-1:0]     cnt_q;    // steps remaining
    logic [2*N-1:0]    product_q;
    logic              busy_q;
    logic              done_q;

    logic [N:0]        sum;
    logic [N:0]        a_d;
    logic [N:0]        q_d;
    logic              skip;

    // One Booth step: add/subtract M by the current bit pair, then arithmetic
    // right shift of the concatenated {S, Q}.
    always_comb begin
        sum = a_q;
        case (q_q[1:0])
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q + ~m_q + ONE;
            default: sum = a_q;
        endcase
        a_d = {sum[N], sum[N:1]};
        q_d = {sum[0], q_q[N:1]};
    end

`ifdef BOOTH_ZERO_SKIP_EN
    assign skip = (bus.multiplicand == '0) || (bus.multiplier == '0);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // done is a pulse unless the final step re-asserts it below.
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        if (skip) begin
                            // Zero operand: result known without iterating.
                            state_q   <= DONE;
                            product_q <= '0;
                            done_q    <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            a_q     <= '0;
                            m_q     <= {bus.multiplicand[N-1], bus.multiplicand};
                            q_q     <= {bus.multiplier, 1'b0};
                            cnt_q   <= CW'(N);
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        // After N shifts the low product half sits in Q above q_-1.
                        product_q <= {a_d[N-1:0], q_d[N:1]};
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.product = product_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;
    localparam int N = 8;
`ifdef BOOTH_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth_mult_seq_if #(.N(N)) bus();

    booth_mult_seq #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference: the signed product, by plain integer arithmetic.
    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        int r;
        r = int'($signed(a)) * int'($signed(b));
        return r[2*N-1:0];
    endfunction

    // Waits for done, sampling on falling edges. cyc = sample index at which done
    // was seen (1 = first falling edge after the start edge), -1 on timeout.
    task automatic wait_done(output int cyc, output int bcnt, output int both);
        cyc  = -1;
        bcnt = 0;
        both = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
            if (bus.busy && bus.done) both++;
            if (bus.busy) bcnt++;
            if (bus.done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        repeat (3) @(negedge clk);
        total++; if (bus.product !== '0) begin bad++; $display("FAIL reset_product got=%h want=0", bus.product); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int cyc, bcnt, both;
        logic [2*N-1:0] held;
        launch(8'd3, 8'hFB);
        wait_done(cyc, bcnt, both);
        total++; if (cyc != N + 1) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", cyc, N + 1); end
        total++; if (bcnt != N) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=%0d", bcnt, N); end
        total++; if (both != 0) begin bad++; $display("FAIL basic_busy_and_done got=%0d want=0", both); end
        total++; if (bus.product !== 16'hFFF1) begin bad++; $display("FAIL basic_product got=%h want=fff1", bus.product); end
        held = bus.product;
        @(negedge clk);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", bus.done); end
        repeat (3) @(negedge clk);
        total++; if (bus.product !== held) begin bad++; $display("FAIL basic_product_hold got=%h want=%h", bus.product, held); end
    endtask

    task automatic test_extremes;
        logic [N-1:0]   ta [4] = '{8'h80, 8'h80, 8'h7F, 8'h7F};
        logic [N-1:0]   tb [4] = '{8'h80, 8'h01, 8'h7F, 8'h80};
        logic [2*N-1:0] tw [4] = '{16'h4000, 16'hFF80, 16'h3F01, 16'hC080};
        int cyc, bcnt, both;
        for (int k = 0; k < 4; k++) begin
            launch(ta[k], tb[k]);
            wait_done(cyc, bcnt, both);
            total++; if (cyc != N + 1) begin bad++; $display("FAIL extreme_latency[%0d] got=%0d want=%0d", k, cyc, N + 1); end
            total++; if (bus.product !== tw[k]) begin bad++; $display("FAIL extreme_product[%0d] got=%h want=%h", k, bus.product, tw[k]); end
            total++; if (bus.product !== ref_mul(ta[k], tb[k])) begin bad++; $display("FAIL extreme_model[%0d] got=%h want=%h", k, bus.product, ref_mul(ta[k], tb[k])); end
        end
    endtask

    task automatic test_random;
        logic [N-1:0] a, b;
        int cyc, bcnt, both, exp_cyc, exp_busy;
        for (int k = 0; k < 24; k++) begin
            a = N'($urandom_range(255, 0));
            b = N'($urandom_range(255, 0));
            if (k == 5) a = '0;
            if (k == 9) b = '0;
            exp_cyc  = (ZS && (a == 0 || b == 0)) ? 1 : N + 1;
            exp_busy = (ZS && (a == 0 || b == 0)) ? 0 : N;
            launch(a, b);
            wait_done(cyc, bcnt, both);
            total++; if (cyc != exp_cyc) begin bad++; $display("FAIL random_latency[%0d] got=%0d want=%0d", k, cyc, exp_cyc); end
            total++; if (bcnt != exp_busy) begin bad++; $display("FAIL random_busy[%0d] got=%0d want=%0d", k, bcnt, exp_busy); end
            total++; if (bus.product !== ref_mul(a, b)) begin bad++; $display("FAIL random_product[%0d] %0d*%0d got=%h want=%h", k, $signed(a), $signed(b), bus.product, ref_mul(a, b)); end
            if (k % 3 == 0) @(negedge clk);
        end
    endtask

    task automatic test_run_changes;
        int first, pulses;
        first  = -1;
        pulses = 0;
        launch(8'd6, 8'd7);
        for (int i = 1; i <= N + 5; i++) begin
            @(negedge clk);
            if (bus.done) begin
                pulses++;
                if (first < 0) first = i;
            end
            bus.start = 1'b0;
            if (i == 3) begin
                bus.start        = 1'b1;
                bus.multiplicand = 8'd9;
                bus.multiplier   = 8'd9;
            end
            if (first == i) begin
                total++; if (bus.product !== 16'h002A) begin bad++; $display("FAIL run_change_product got=%h want=002a", bus.product); end
            end
        end
        total++; if (first != N + 1) begin bad++; $display("FAIL run_change_latency got=%0d want=%0d", first, N + 1); end
        total++; if (pulses != 1) begin bad++; $display("FAIL run_change_done_count got=%0d want=1", pulses); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL run_change_idle_busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_back_to_back;
        int cyc, bcnt, both;
        launch(8'd4, 8'd4);
        wait_done(cyc, bcnt, both);
        total++; if (bus.product !== 16'h0010) begin bad++; $display("FAIL b2b_first got=%h want=0010", bus.product); end
        // Still inside the DONE cycle: request the next operation.
        bus.start        = 1'b1;
        bus.multiplicand = 8'd2;
        bus.multiplier   = 8'd2;
        wait_done(cyc, bcnt, both);
        total++; if (cyc != N + 1) begin bad++; $display("FAIL b2b_spacing got=%0d want=%0d", cyc, N + 1); end
        total++; if (bcnt != N) begin bad++; $display("FAIL b2b_busy got=%0d want=%0d", bcnt, N); end
        total++; if (both != 0) begin bad++; $display("FAIL b2b_busy_and_done got=%0d want=0", both); end
        total++; if (bus.product !== 16'h0004) begin bad++; $display("FAIL b2b_second got=%h want=0004", bus.product); end
    endtask

    task automatic test_reset_mid;
        int cyc, bcnt, both;
        launch(8'd10, 8'd10);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL midreset_done got=%b want=0", bus.done); end
        total++; if (bus.product !== '0) begin bad++; $display("FAIL midreset_product got=%h want=0", bus.product); end
        @(negedge clk);
        rst = 1'b0;
        launch(8'd10, 8'd10);
        wait_done(cyc, bcnt, both);
        total++; if (cyc != N + 1) begin bad++; $display("FAIL midreset_latency got=%0d want=%0d", cyc, N + 1); end
        total++; if (bus.product !== 16'h0064) begin bad++; $display("FAIL midreset_product_after got=%h want=0064", bus.product); end
    endtask

    task automatic test_zero;
        int cyc, bcnt, both, exp_cyc, exp_busy;
        // Leave a nonzero product behind so a zero result is a real change.
        launch(8'd5, 8'd5);
        wait_done(cyc, bcnt, both);
        exp_cyc  = ZS ? 1 : N + 1;
        exp_busy = ZS ? 0 : N;
        launch(8'd0, 8'd55);
        wait_done(cyc, bcnt, both);
        total++; if (cyc != exp_cyc) begin bad++; $display("FAIL zero_latency got=%0d want=%0d", cyc, exp_cyc); end
        total++; if (bcnt != exp_busy) begin bad++; $display("FAIL zero_busy got=%0d want=%0d", bcnt, exp_busy); end
        total++; if (bus.product !== '0) begin bad++; $display("FAIL zero_product got=%h want=0", bus.product); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_extremes;
        test_random;
        test_run_changes;
        test_back_to_back;
        test_reset_mid;
        test_zero;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
